// File: rtl/rr_grant_lut.sv
// rr_grant_lut: round-robin grant table for one fixed value of the last-granted pointer.
// The table maps every eligible vector to the first eligible port after LAST.
module rr_grant_lut #(
    parameter int NB_PORTS      = 4,
    parameter int LOG2_NB_PORTS = 2,
    parameter int LAST          = 0
) (
    input  logic [NB_PORTS-1:0]      eligible_i,
    output logic [LOG2_NB_PORTS-1:0] grant_o,
    output logic                     valid_o
);

    localparam int LUT_SIZE = 2 ** NB_PORTS;
    localparam int LUT_BITS = LUT_SIZE * LOG2_NB_PORTS;

    // Scanning from the farthest port back to the nearest lets the nearest one win.
    function automatic logic [LUT_BITS-1:0] buildLut();
        logic [LUT_BITS-1:0] tbl;
        int                  idx;
        tbl = '0;
        for (int v = 0; v < LUT_SIZE; v++) begin
            for (int k = NB_PORTS; k >= 1; k--) begin
                idx = (LAST + k) % NB_PORTS;
                if (((v >> idx) & 1) == 1) begin
                    tbl[v*LOG2_NB_PORTS +: LOG2_NB_PORTS] = idx[LOG2_NB_PORTS-1:0];
                end
            end
        end
        return tbl;
    endfunction

    localparam logic [LUT_BITS-1:0] lut = buildLut();

    // Look up the grant for the current eligible vector; an empty vector means no grant.
    always_comb begin
        grant_o = lut[int'(eligible_i)*LOG2_NB_PORTS +: LOG2_NB_PORTS];
        valid_o = |eligible_i;
    end

endmodule

// File: rtl/shmem_rr_mux.sv
// shmem_rr_mux: round-robin multiplexer of NB_PORTS request/done clients onto one
// single-port synchronous RAM port, one access per cycle with pipelined reads.
module shmem_rr_mux #(
    parameter int NB_PORTS            = 4,
    parameter int LOG2_NB_PORTS       = 2,
    parameter int ADDR_WIDTH          = 12,
    parameter int DATA_WIDTH          = 32,
    parameter int REGISTER_MEM_OUTPUT = 1
) (
    input  logic                           clk,
    input  logic                           srst,
    input  logic [NB_PORTS-1:0]            shmem_request,
    input  logic [NB_PORTS-1:0]            shmem_wren,
    input  logic [NB_PORTS*ADDR_WIDTH-1:0] shmem_addr,
    input  logic [NB_PORTS*DATA_WIDTH-1:0] shmem_datain,
    output logic [NB_PORTS*DATA_WIDTH-1:0] shmem_dataout,
    output logic [NB_PORTS-1:0]            shmem_done,
    output logic                           mem_wren,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_datain,
    input  logic [DATA_WIDTH-1:0]          mem_dataout
);

    localparam int READ_LAT   = 1 + REGISTER_MEM_OUTPUT;
    // One stage is loaded at the grant edge alongside mem_addr, then READ_LAT more
    // stages follow the RAM; the last stage marks the cycle mem_dataout is valid.
    localparam int PIPE_DEPTH = READ_LAT + 1;
    localparam logic [LOG2_NB_PORTS-1:0] LAST_RESET = LOG2_NB_PORTS'(NB_PORTS - 1);

    logic [LOG2_NB_PORTS-1:0] lutGrant [NB_PORTS];
    logic [NB_PORTS-1:0]      lutValid;
    logic [NB_PORTS-1:0]      eligible;
    logic [LOG2_NB_PORTS-1:0] grantIdx;
    logic                     grantValid;

    logic [LOG2_NB_PORTS-1:0]      last_q, last_d;
    logic [NB_PORTS-1:0]           busy_q, busy_d;
    logic [PIPE_DEPTH-1:0]         pipeValid_q, pipeValid_d;
    logic [LOG2_NB_PORTS-1:0]      pipePort_q [PIPE_DEPTH];
    logic [LOG2_NB_PORTS-1:0]      pipePort_d [PIPE_DEPTH];
    logic                          memWren_q, memWren_d;
    logic [ADDR_WIDTH-1:0]         memAddr_q, memAddr_d;
    logic [DATA_WIDTH-1:0]         memDatain_q, memDatain_d;
    logic [NB_PORTS-1:0]           done_q, done_d;
    logic [NB_PORTS*DATA_WIDTH-1:0] dataout_q, dataout_d;

    // One grant table per possible pointer value; the pointer picks which one is used.
    for (genvar g = 0; g < NB_PORTS; g++) begin : gLut
        rr_grant_lut #(
            .NB_PORTS      (NB_PORTS),
            .LOG2_NB_PORTS (LOG2_NB_PORTS),
            .LAST          (g)
        ) u_lut (
            .eligible_i (eligible),
            .grant_o    (lutGrant[g]),
            .valid_o    (lutValid[g])
        );
    end

    // A port competes only when requesting, not just completed, and with no read in flight.
    always_comb begin
        eligible   = shmem_request & ~done_q & ~busy_q;
        grantIdx   = lutGrant[last_q];
        grantValid = lutValid[last_q];
    end

    // Next state: retire the oldest read, advance the read pipeline, launch the new grant.
    always_comb begin
        int sel;
        int exitSel;
        last_d      = last_q;
        busy_d      = busy_q;
        memWren_d   = 1'b0;
        memAddr_d   = memAddr_q;
        memDatain_d = memDatain_q;
        done_d      = '0;
        dataout_d   = dataout_q;
        pipeValid_d = '0;
        for (int s = 0; s < PIPE_DEPTH; s++) begin
            pipePort_d[s] = '0;
        end
        for (int s = 1; s < PIPE_DEPTH; s++) begin
            pipeValid_d[s] = pipeValid_q[s-1];
            pipePort_d[s]  = pipePort_q[s-1];
        end

        exitSel = int'(pipePort_q[PIPE_DEPTH-1]);
        if (pipeValid_q[PIPE_DEPTH-1]) begin
            dataout_d[exitSel*DATA_WIDTH +: DATA_WIDTH] = mem_dataout;
            done_d[exitSel] = 1'b1;
            busy_d[exitSel] = 1'b0;
        end

        sel = int'(grantIdx);
        if (grantValid) begin
            last_d      = grantIdx;
            memWren_d   = shmem_wren[sel];
            memAddr_d   = shmem_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
            memDatain_d = shmem_datain[sel*DATA_WIDTH +: DATA_WIDTH];
            if (shmem_wren[sel]) begin
                // A write is finished from the client's view as soon as it reaches the RAM.
                done_d[sel] = 1'b1;
            end else begin
                busy_d[sel]    = 1'b1;
                pipeValid_d[0] = 1'b1;
                pipePort_d[0]  = grantIdx;
            end
        end
    end

    // State and output registers; reset drops any reads still in flight.
    always_ff @(posedge clk) begin
        if (srst) begin
            last_q      <= LAST_RESET;
            busy_q      <= '0;
            pipeValid_q <= '0;
            for (int s = 0; s < PIPE_DEPTH; s++) begin
                pipePort_q[s] <= '0;
            end
            memWren_q   <= 1'b0;
            memAddr_q   <= '0;
            memDatain_q <= '0;
            done_q      <= '0;
            dataout_q   <= '0;
        end else begin
            last_q      <= last_d;
            busy_q      <= busy_d;
            pipeValid_q <= pipeValid_d;
            pipePort_q  <= pipePort_d;
            memWren_q   <= memWren_d;
            memAddr_q   <= memAddr_d;
            memDatain_q <= memDatain_d;
            done_q      <= done_d;
            dataout_q   <= dataout_d;
        end
    end

    assign mem_wren      = memWren_q;
    assign mem_addr      = memAddr_q;
    assign mem_datain    = memDatain_q;
    assign shmem_done    = done_q;
    assign shmem_dataout = dataout_q;

endmodule

// File: tb/tb_shmem_rr_mux.sv
// tb_shmem_rr_mux: self-checking bench for shmem_rr_mux with a RAM model on its port.
module tb_shmem_rr_mux;

    localparam int NB        = 4;
    localparam int LOG2      = 2;
    localparam int AW        = 12;
    localparam int DW        = 32;
    localparam int REG       = 1;
    localparam int READ_LAT  = 1 + REG;
    localparam int RAM_WORDS = 4096;

    logic              clk;
    logic              srst;
    logic [NB-1:0]     req;
    logic [NB-1:0]     wren;
    logic [NB*AW-1:0]  addr;
    logic [NB*DW-1:0]  din;
    logic [NB*DW-1:0]  dout;
    logic [NB-1:0]     done;
    logic              memWren;
    logic [AW-1:0]     memAddr;
    logic [DW-1:0]     memDin;
    logic [DW-1:0]     memDout;

    logic [NB-1:0]     lutElig;
    logic [LOG2-1:0]   lutGrant;
    logic              lutValid;

    logic [DW-1:0]     ram [RAM_WORDS];
    logic [DW-1:0]     rdStage;
    logic [DW-1:0]     rdOut;
    logic              bdEn;
    logic [AW-1:0]     bdAddr;
    logic [DW-1:0]     bdData;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    shmem_rr_mux #(
        .NB_PORTS            (NB),
        .LOG2_NB_PORTS       (LOG2),
        .ADDR_WIDTH          (AW),
        .DATA_WIDTH          (DW),
        .REGISTER_MEM_OUTPUT (REG)
    ) dut (
        .clk           (clk),
        .srst          (srst),
        .shmem_request (req),
        .shmem_wren    (wren),
        .shmem_addr    (addr),
        .shmem_datain  (din),
        .shmem_dataout (dout),
        .shmem_done    (done),
        .mem_wren      (memWren),
        .mem_addr      (memAddr),
        .mem_datain    (memDin),
        .mem_dataout   (memDout)
    );

    rr_grant_lut #(
        .NB_PORTS      (NB),
        .LOG2_NB_PORTS (LOG2),
        .LAST          (0)
    ) u_lut (
        .eligible_i (lutElig),
        .grant_o    (lutGrant),
        .valid_o    (lutValid)
    );

    // RAM port A: synchronous read plus optional output register; backdoor for preloading
    always @(posedge clk) begin
        if (bdEn) ram[bdAddr] <= bdData;
        else if (memWren) ram[memAddr] <= memDin;
        rdStage <= ram[memAddr];
        rdOut   <= rdStage;
    end
    assign memDout = (REG != 0) ? rdOut : rdStage;

    task automatic applyReset();
        srst = 1'b1; req = '0; wren = '0; addr = '0; din = '0; bdEn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        srst = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bdEn = 1'b1; bdAddr = a; bdData = d;
        @(posedge clk);
        #1;
        bdEn = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1; req = '1; wren = '1; bdEn = 1'b0; bdAddr = '0; bdData = '0;
        addr = {$urandom, $urandom};
        din  = {$urandom, $urandom, $urandom, $urandom};
        lutElig = '0;
        @(posedge clk);
        #1;
        checks++; if (memWren !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_wren got=%0b exp=0", memWren); end
        checks++; if (memAddr !== '0) begin failures++; $display("[TB] FAIL reset_mem_addr got=%0h exp=0", memAddr); end
        checks++; if (memDin !== '0) begin failures++; $display("[TB] FAIL reset_mem_datain got=%0h exp=0", memDin); end
        checks++; if (done !== '0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0000", done); end
        checks++; if (dout !== '0) begin failures++; $display("[TB] FAIL reset_dataout got=%0h exp=0", dout); end
        applyReset();
    endtask

    task automatic test_lut();
        logic [NB-1:0] fixedElig [3];
        int            fixedExp [3];
        logic [NB-1:0] ev;
        int            expG;
        bit            found;
        fixedElig[0] = 4'b0101; fixedExp[0] = 2;
        fixedElig[1] = 4'b0001; fixedExp[1] = 0;
        fixedElig[2] = 4'b1010; fixedExp[2] = 1;
        for (int i = 0; i < 3; i++) begin
            lutElig = fixedElig[i];
            #1;
            checks++;
            if (lutGrant !== LOG2'(fixedExp[i]) || lutValid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL lut_fixed elig=%b got=%0d/%0b exp=%0d/1", fixedElig[i], lutGrant, lutValid, fixedExp[i]);
            end
        end
        for (int v = 0; v < 2 ** NB; v++) begin
            ev = NB'(v);
            found = 1'b0; expG = 0;
            for (int k = 1; k <= NB; k++) begin
                if (!found && ev[k % NB]) begin found = 1'b1; expG = k % NB; end
            end
            lutElig = ev;
            #1;
            checks++;
            if (lutValid !== found || (found && lutGrant !== LOG2'(expG))) begin
                failures++;
                $display("[TB] FAIL lut_sweep elig=%b got=%0d/%0b exp=%0d/%0b", ev, lutGrant, lutValid, expG, found);
            end
        end
    endtask

    task automatic test_single_write();
        bit expOn;
        applyReset();
        req[1] = 1'b1; wren[1] = 1'b1;
        addr[1*AW +: AW] = 12'h005;
        din[1*DW +: DW]  = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            expOn = (k == 0 || k == 2);
            checks++; if (done !== (expOn ? 4'b0010 : 4'b0000)) begin failures++; $display("[TB] FAIL wr_done cyc=%0d got=%b exp_on=%0b", k, done, expOn); end
            checks++; if (memWren !== expOn) begin failures++; $display("[TB] FAIL wr_mem_wren cyc=%0d got=%0b exp=%0b", k, memWren, expOn); end
            if (k == 0) begin
                checks++; if (memAddr !== 12'h005) begin failures++; $display("[TB] FAIL wr_mem_addr got=%0h exp=005", memAddr); end
                checks++; if (memDin !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL wr_mem_datain got=%0h exp=deadbeef", memDin); end
            end
            if (k == 2) req[1] = 1'b0;
        end
        checks++; if (ram[5] !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL wr_ram got=%0h exp=deadbeef", ram[5]); end
    endtask

    task automatic test_stream_writes();
        int cnt [NB];
        int port, expA, streamErrs, firstBad, ramErrs;
        applyReset();
        for (int k = 0; k < NB; k++) begin
            cnt[k] = 0;
            addr[k*AW +: AW] = AW'(1024 * k);
            din[k*DW +: DW]  = DW'(1024 * k);
        end
        req = '1; wren = '1;
        streamErrs = 0; firstBad = -1;
        for (int n = 0; n < RAM_WORDS; n++) begin
            @(posedge clk);
            #1;
            port = n % NB;
            expA = 1024 * port + n / NB;
            if (memWren !== 1'b1 || memAddr !== AW'(expA) || memDin !== DW'(expA) || done !== (NB'(1) << port)) begin
                streamErrs++;
                if (firstBad < 0) firstBad = n;
            end
            cnt[port]++;
            if (cnt[port] == 1024) req[port] = 1'b0;
            else begin
                addr[port*AW +: AW] = AW'(1024 * port + cnt[port]);
                din[port*DW +: DW]  = DW'(1024 * port + cnt[port]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (streamErrs !== 0) begin failures++; $display("[TB] FAIL stream_order bad_cycles=%0d first=%0d exp=0", streamErrs, firstBad); end
        checks++; if (memWren !== 1'b0) begin failures++; $display("[TB] FAIL stream_idle_wren got=%0b exp=0", memWren); end
        ramErrs = 0;
        for (int a = 0; a < RAM_WORDS; a++) if (ram[a] !== DW'(a)) ramErrs++;
        checks++; if (ramErrs !== 0) begin failures++; $display("[TB] FAIL stream_ram bad_words=%0d exp=0", ramErrs); end
    endtask

    task automatic test_read_after_write();
        applyReset();
        req[2] = 1'b1; wren[2] = 1'b1;
        addr[2*AW +: AW] = 12'h010;
        din[2*DW +: DW]  = 32'h00001234;
        @(posedge clk);
        #1;
        checks++; if (done !== 4'b0100 || memWren !== 1'b1) begin failures++; $display("[TB] FAIL raw_write done=%b wren=%0b exp=0100/1", done, memWren); end
        req[2] = 1'b0;
        @(posedge clk);
        #1;
        req[2] = 1'b1; wren[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                checks++; if (memWren !== 1'b0 || memAddr !== 12'h010) begin failures++; $display("[TB] FAIL raw_issue wren=%0b addr=%0h exp=0/010", memWren, memAddr); end
            end
            checks++;
            if (done !== (k == 3 ? 4'b0100 : 4'b0000)) begin failures++; $display("[TB] FAIL raw_done cyc=%0d got=%b", k, done); end
            if (k >= 3) begin
                checks++; if (dout[2*DW +: DW] !== 32'h00001234) begin failures++; $display("[TB] FAIL raw_data cyc=%0d got=%0h exp=1234", k, dout[2*DW +: DW]); end
            end
            if (k == 3) req[2] = 1'b0;
        end
    endtask

    task automatic test_interleave();
        int done0, done3;
        preload(12'h020, 32'hCAFE0000);
        applyReset();
        req[0] = 1'b1; wren[0] = 1'b0; addr[0*AW +: AW] = 12'h020;
        req[3] = 1'b1; wren[3] = 1'b1; addr[3*AW +: AW] = 12'h030; din[3*DW +: DW] = 32'h0BADF00D;
        done0 = 0; done3 = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done[0]) done0++;
            if (done[3]) done3++;
            if (k == 0) begin
                checks++; if (memWren !== 1'b0 || memAddr !== 12'h020) begin failures++; $display("[TB] FAIL il_read_issue wren=%0b addr=%0h exp=0/020", memWren, memAddr); end
            end
            if (k == 1) begin
                checks++; if (memWren !== 1'b1 || memAddr !== 12'h030 || done !== 4'b1000) begin failures++; $display("[TB] FAIL il_write wren=%0b addr=%0h done=%b exp=1/030/1000", memWren, memAddr, done); end
                req[3] = 1'b0;
            end
            if (k == 3) begin
                checks++; if (done !== 4'b0001 || dout[0 +: DW] !== 32'hCAFE0000) begin failures++; $display("[TB] FAIL il_read_done done=%b data=%0h exp=0001/cafe0000", done, dout[0 +: DW]); end
                req[0] = 1'b0;
            end
        end
        checks++; if (done0 !== 1 || done3 !== 1) begin failures++; $display("[TB] FAIL il_done_count p0=%0d p3=%0d exp=1/1", done0, done3); end
        checks++; if (ram[12'h030] !== 32'h0BADF00D) begin failures++; $display("[TB] FAIL il_ram got=%0h exp=0badf00d", ram[12'h030]); end
    endtask

    task automatic test_reset_mid_read();
        bit doneSeen;
        applyReset();
        req[1] = 1'b1; wren[1] = 1'b0; addr[1*AW +: AW] = 12'h020;
        @(posedge clk);
        #1;
        checks++; if (memAddr !== 12'h020) begin failures++; $display("[TB] FAIL rmr_issue addr=%0h exp=020", memAddr); end
        @(posedge clk);
        #1;
        srst = 1'b1; req = '0;
        @(posedge clk);
        #1;
        checks++;
        if (memWren !== 1'b0 || memAddr !== '0 || memDin !== '0 || done !== '0 || dout !== '0) begin
            failures++;
            $display("[TB] FAIL rmr_reset_outputs wren=%0b addr=%0h din=%0h done=%b dout=%0h exp=all zero", memWren, memAddr, memDin, done, dout);
        end
        srst = 1'b0;
        doneSeen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done !== '0) doneSeen = 1'b1;
        end
        checks++; if (doneSeen !== 1'b0) begin failures++; $display("[TB] FAIL rmr_stray_done got=1 exp=0"); end
    endtask

    task automatic test_random();
        logic [NB-1:0]    expDone, pend, elig, newDone;
        int               due [NB];
        logic [DW-1:0]    pendData [NB];
        logic [DW-1:0]    mm [16];
        logic [NB*DW-1:0] expDout;
        logic             expWren;
        logic [AW-1:0]    expAddr;
        logic [DW-1:0]    expDin;
        int               mLast, g, idx, a;
        bit               found;
        for (int i = 0; i < 16; i++) begin
            mm[i] = DW'($urandom);
            preload(AW'(i), mm[i]);
        end
        applyReset();
        expDone = '0; pend = '0; expDout = '0; expWren = 1'b0; expAddr = '0; expDin = '0;
        mLast = NB - 1;
        for (int p = 0; p < NB; p++) begin due[p] = 0; pendData[p] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            elig = req & ~expDone & ~pend;
            newDone = '0;
            for (int p = 0; p < NB; p++) begin
                if (pend[p] && due[p] == cyc) begin
                    newDone[p] = 1'b1;
                    expDout[p*DW +: DW] = pendData[p];
                    pend[p] = 1'b0;
                end
            end
            found = 1'b0; g = 0;
            for (int k = 1; k <= NB; k++) begin
                idx = (mLast + k) % NB;
                if (!found && elig[idx]) begin found = 1'b1; g = idx; end
            end
            if (found) begin
                mLast   = g;
                a       = int'(addr[g*AW +: AW]);
                expWren = wren[g];
                expAddr = addr[g*AW +: AW];
                expDin  = din[g*DW +: DW];
                if (wren[g]) begin
                    mm[a] = din[g*DW +: DW];
                    newDone[g] = 1'b1;
                end else begin
                    pend[g] = 1'b1;
                    due[g] = cyc + READ_LAT + 1;
                    pendData[g] = mm[a];
                end
            end else begin
                expWren = 1'b0;
            end
            expDone = newDone;
            #1;
            checks++; if (done !== expDone) begin failures++; $display("[TB] FAIL rnd_done cyc=%0d got=%b exp=%b", cyc, done, expDone); end
            checks++; if (dout !== expDout) begin failures++; $display("[TB] FAIL rnd_dataout cyc=%0d got=%0h exp=%0h", cyc, dout, expDout); end
            checks++; if (memWren !== expWren) begin failures++; $display("[TB] FAIL rnd_mem_wren cyc=%0d got=%0b exp=%0b", cyc, memWren, expWren); end
            checks++; if (memAddr !== expAddr) begin failures++; $display("[TB] FAIL rnd_mem_addr cyc=%0d got=%0h exp=%0h", cyc, memAddr, expAddr); end
            checks++; if (memDin !== expDin) begin failures++; $display("[TB] FAIL rnd_mem_datain cyc=%0d got=%0h exp=%0h", cyc, memDin, expDin); end
            for (int p = 0; p < NB; p++) begin
                if (expDone[p] || !req[p]) begin
                    if ($urandom_range(2, 0) != 0) begin
                        req[p]  = 1'b1;
                        wren[p] = 1'($urandom_range(1, 0));
                        addr[p*AW +: AW] = AW'($urandom_range(15, 0));
                        din[p*DW +: DW]  = DW'($urandom);
                    end else begin
                        req[p] = 1'b0;
                    end
                end
            end
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_lut();
        test_single_write();
        test_stream_writes();
        test_read_after_write();
        test_interleave();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
